// File: rtl/rsdec_pkg.sv
// Shared definitions for the RS decoder: symbol width, Chien load depth and
// the Chien sequencer state encoding.
package rsdec_pkg;

    localparam int GF_W      = 8;
    localparam int CHIEN_PAR = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHORT,
        ST_LOAD,
        ST_SEARCH,
        ST_DONE
    } chien_state_t;

endpackage

// File: rtl/rsdec_chien_ctrl.sv
// Chien-Forney search sequencer: walks the search unit through shortening,
// coefficient load and position search, and counts roots against the BM degree.
module rsdec_chien_ctrl
    import rsdec_pkg::*;
#(
    parameter int N = 255
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic [1:0]      deg,
    output logic [1:0]      coef_idx,
    output logic            shorten,
    output logic            load,
    output logic            search,
    input  logic [GF_W-1:0] err_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [GF_W-1:0] out_pos,
    output logic [GF_W-1:0] out_err,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [GF_W-1:0] err_cnt
);

    localparam int            SHORT_CYC = 255 - N;
    localparam logic [GF_W-1:0] SHORT_M1 = GF_W'(SHORT_CYC - 1);
    localparam logic [GF_W-1:0] LOAD_M1  = GF_W'(CHIEN_PAR - 1);
    localparam logic [GF_W-1:0] LAST_POS = GF_W'(N - 1);

    chien_state_t    state_q;
    logic [GF_W-1:0] cyc_q;
    logic [GF_W-1:0] pos_q;
    logic [GF_W-1:0] err_cnt_q;
    logic [GF_W-1:0] err_cnt_d;
    logic [1:0]      deg_q;
    logic            fail_q;

    // Saturating root count including the position being transferred now, so a
    // root at position 0 is already counted when fail is decided.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((err_in != '0) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // NOTE: every register here is written with <= so all state updates take
    // effect together at the clock edge, independent of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= ST_IDLE;
            cyc_q     <= '0;
            pos_q     <= '0;
            err_cnt_q <= '0;
            deg_q     <= '0;
            fail_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        deg_q     <= deg;
                        err_cnt_q <= '0;
                        fail_q    <= 1'b0;
                        if (SHORT_CYC > 0) begin
                            state_q <= ST_SHORT;
                            cyc_q   <= SHORT_M1;
                        end else begin
                            state_q <= ST_LOAD;
                            cyc_q   <= LOAD_M1;
                        end
                    end
                end
                ST_SHORT: begin
                    if (cyc_q == '0) begin
                        state_q <= ST_LOAD;
                        cyc_q   <= LOAD_M1;
                    end else begin
                        cyc_q <= cyc_q - 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cyc_q == '0) begin
                        state_q <= ST_SEARCH;
                        pos_q   <= LAST_POS;
                    end else begin
                        cyc_q <= cyc_q - 1'b1;
                    end
                end
                ST_SEARCH: begin
                    if (out_ready) begin
                        err_cnt_q <= err_cnt_d;
                        if (pos_q == '0) begin
                            state_q <= ST_DONE;
                            fail_q  <= (err_cnt_d != {6'b0, deg_q});
                        end else begin
                            pos_q <= pos_q - 1'b1;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes are pure state decodes; only search also looks at out_ready.
    assign shorten   = (state_q == ST_SHORT);
    assign load      = (state_q == ST_LOAD);
    assign coef_idx  = load ? cyc_q[1:0] : 2'b00;
    assign out_valid = (state_q == ST_SEARCH);
    assign search    = out_valid & out_ready;
    assign out_pos   = pos_q;
    assign out_err   = out_valid ? err_in : '0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign fail      = fail_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rsdec_chien_ctrl.sv
// Directed bench for rsdec_chien_ctrl: table of full blocks at N=255 plus
// hand sequences for shortening (N=204) and reset abort.
module tb_rsdec_chien_ctrl;

    typedef struct {
        logic [1:0] deg;
        int         ra;
        int         rb;
        bit         bp;
        int         st_pos;
        logic [7:0] exp_cnt;
        logic       exp_fail;
    } blk_t;

    logic       clk = 1'b0;
    logic       clrn;
    logic       start;
    logic [1:0] deg;
    logic [1:0] coef_idx;
    logic       shorten, load, search;
    logic [7:0] err_in;
    logic       out_valid, out_ready;
    logic [7:0] out_pos, out_err;
    logic       busy, done, fail;
    logic [7:0] err_cnt;

    logic       start_s;
    logic [1:0] deg_s;
    logic [1:0] coef_idx_s;
    logic       shorten_s, load_s, search_s;
    logic [7:0] err_in_s;
    logic       out_valid_s, out_ready_s;
    logic [7:0] out_pos_s, out_err_s;
    logic       busy_s, done_s, fail_s;
    logic [7:0] err_cnt_s;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    rsdec_chien_ctrl #(.N(255)) u_dut (
        .clk(clk), .clrn(clrn), .start(start), .deg(deg), .coef_idx(coef_idx),
        .shorten(shorten), .load(load), .search(search), .err_in(err_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
        .out_err(out_err), .busy(busy), .done(done), .fail(fail), .err_cnt(err_cnt)
    );

    rsdec_chien_ctrl #(.N(204)) u_short (
        .clk(clk), .clrn(clrn), .start(start_s), .deg(deg_s), .coef_idx(coef_idx_s),
        .shorten(shorten_s), .load(load_s), .search(search_s), .err_in(err_in_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_pos(out_pos_s),
        .out_err(out_err_s), .busy(busy_s), .done(done_s), .fail(fail_s), .err_cnt(err_cnt_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_shorten"},   shorten,   0);
        check({tag, "_load"},      load,      0);
        check({tag, "_search"},    search,    0);
        check({tag, "_coef_idx"},  coef_idx,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_pos"},   out_pos,   0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_fail"},      fail,      0);
        check({tag, "_err_cnt"},   err_cnt,   0);
    endtask

    // One full N=255 block; the bench tracks the expected position itself and
    // plays the search unit by driving err_in at the chosen root positions.
    task automatic run_block(input blk_t v);
        int exp_pos;
        int k;
        @(negedge clk);
        start = 1'b1;
        deg   = v.deg;
        @(negedge clk);
        start = 1'b0;
        deg   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            check("load", load, 1);
            check("coef_idx", coef_idx, 3 - i);
            check("out_valid_load", out_valid, 0);
            @(negedge clk);
        end
        exp_pos = 254;
        k = 0;
        while (exp_pos >= 0 && k < 1000) begin
            out_ready = !(v.bp && (k % 4 == 1 || k % 4 == 2));
            err_in    = (exp_pos == v.ra || exp_pos == v.rb) ? 8'((exp_pos & 127) | 128) : 8'h00;
            start     = (exp_pos == v.st_pos);
            deg       = start ? 2'd3 : 2'd0;
            #1;
            check("out_valid", out_valid, 1);
            check("out_pos", out_pos, exp_pos);
            check("search", search, out_ready);
            check("out_err", out_err, err_in);
            if (!out_valid) break;
            if (out_ready) exp_pos--;
            k++;
            @(negedge clk);
        end
        start     = 1'b0;
        deg       = 2'd0;
        out_ready = 1'b1;
        err_in    = 8'h00;
        check("transfers_left", exp_pos, -1);
        check("done", done, 1);
        check("fail", fail, v.exp_fail);
        check("err_cnt", err_cnt, v.exp_cnt);
        check("out_valid_done", out_valid, 0);
        @(negedge clk);
        check("done_clear", done, 0);
        check("busy_idle", busy, 0);
        check("fail_hold", fail, v.exp_fail);
        check("err_cnt_hold", err_cnt, v.exp_cnt);
    endtask

    initial begin
        blk_t vec[5];
        int   cnt;
        int   k;
        vec[0] = '{deg: 2'd2, ra: 200, rb: 10,  bp: 1'b0, st_pos: -1,  exp_cnt: 8'd2, exp_fail: 1'b0};
        vec[1] = '{deg: 2'd3, ra: 100, rb: -1,  bp: 1'b0, st_pos: -1,  exp_cnt: 8'd1, exp_fail: 1'b1};
        vec[2] = '{deg: 2'd2, ra: 0,   rb: 254, bp: 1'b1, st_pos: -1,  exp_cnt: 8'd2, exp_fail: 1'b0};
        vec[3] = '{deg: 2'd1, ra: 50,  rb: -1,  bp: 1'b0, st_pos: 120, exp_cnt: 8'd1, exp_fail: 1'b0};
        vec[4] = '{deg: 2'd0, ra: -1,  rb: -1,  bp: 1'b1, st_pos: 7,   exp_cnt: 8'd0, exp_fail: 1'b0};

        clrn        = 1'b0;
        start       = 1'b0;
        deg         = 2'd0;
        err_in      = 8'h00;
        out_ready   = 1'b1;
        start_s     = 1'b0;
        deg_s       = 2'd0;
        err_in_s    = 8'h00;
        out_ready_s = 1'b1;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        for (int i = 0; i < 5; i++) run_block(vec[i]);

        // Shortened code: 51 shorten cycles, 4 load cycles, first position 203.
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cnt = 0;
        while (shorten_s && cnt < 100) begin
            check("short_no_load", load_s, 0);
            cnt++;
            @(negedge clk);
        end
        check("shorten_cycles", cnt, 51);
        for (int i = 0; i < 4; i++) begin
            check("short_load", load_s, 1);
            check("short_coef_idx", coef_idx_s, 3 - i);
            @(negedge clk);
        end
        check("short_first_valid", out_valid_s, 1);
        check("short_first_pos", out_pos_s, 203);
        k = 0;
        while (!done_s && k < 400) begin
            k++;
            @(negedge clk);
        end
        check("short_transfers", k, 204);
        check("short_done", done_s, 1);
        check("short_fail", fail_s, 0);
        check("short_err_cnt", err_cnt_s, 0);

        // Abort during LOAD, then a fresh block must run normally.
        @(negedge clk);
        start = 1'b1;
        deg   = 2'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_in_load", load, 1);
        clrn = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        check_reset_outputs("abort_next");
        clrn = 1'b1;
        run_block(vec[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rsdec_chien_ctrl.md
# rsdec_chien_ctrl

Sequencer for the RS(255-class, GF(2^8)) Chien-Forney search unit. It accepts a start pulse from the Berlekamp-Massey stage and drives the search unit's `shorten`, `load` and `search` strobes. It presents one evaluated codeword position per transfer to the downstream corrector through a valid/ready handshake. It counts located roots and flags decoder failure when that count differs from the error-locator degree.

## Interface
Parameters:
- N, 255, codeword length in symbols (1..255); shortening cycles SHORT = 255-N

Ports:
- clk  in  1  clock
- clrn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; lambda/omega ready upstream
- deg  in  2  error-locator degree from BM, sampled on accepted start
- coef_idx  out  2  coefficient index upstream must present on lambda/omega this cycle
- shorten  out  1  to search unit
- load  out  1  to search unit
- search  out  1  to search unit
- err_in  in  8  search unit `error` output (nonzero = root at current position)
- out_valid  out  1  position result available
- out_ready  in  1  downstream accepts
- out_pos  out  8  current position index
- out_err  out  8  error magnitude for out_pos (err_in passed through)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last position
- fail  out  1  valid with done: root count != deg
- err_cnt  out  8  roots found in current/last block

## Operation
- States: IDLE, SHORT, LOAD, SEARCH, DONE.
- IDLE: start=1 latches deg, clears err_cnt, loads cyc counter; goes to SHORT if SHORT>0, else LOAD. start outside IDLE is ignored.
- SHORT: shorten=1 for exactly SHORT cycles, then LOAD.
- LOAD: load=1 for exactly 4 cycles; coef_idx = 3,2,1,0 in that order (highest coefficient first), then SEARCH with pos = N-1.
- SEARCH: out_valid=1, out_pos=pos, out_err=err_in (combinational). Transfer = out_valid & out_ready. search = transfer; datapath is frozen while out_ready=0.
- On transfer: if err_in != 0, err_cnt increments (saturates at 255). If pos==0, go to DONE, else pos decrements.
- DONE: one cycle; done=1, fail = (err_cnt != {6'b0,deg}); then IDLE. err_cnt and fail hold until the next accepted start.
- Outside their states, shorten/load/search/out_valid are 0 and coef_idx is 0.

## Timing
- Reset: state=IDLE; all strobes 0, out_valid=0, done=0, fail=0, busy=0, err_cnt=0, out_pos=0, coef_idx=0.
- clrn mid-block aborts immediately to IDLE. No done is issued. The search unit is reset by the same clrn.
- Strobes are registered-state decodes (Moore), except search, which depends combinationally on out_ready.
- Latency from start to first out_valid: SHORT+4+1 cycles (N=255: 5 cycles).
- With out_ready held high, one position per cycle; block time = SHORT+4+N+1 cycles plus idle.
- Root at pos 0 is counted before the fail compare in DONE.
- N=255: SHORT state is never entered. N=1: SEARCH lasts one transfer.

## Structure
- Shared package rsdec_pkg: GF_W=8 localparam, CHIEN_PAR=4 (load cycles), state enum type chien_state_t.
- Single module; no sub-module. Counters: cyc (8-bit, shared by SHORT/LOAD), pos (8-bit), err_cnt (8-bit).

## Test plan
- Reset, N=255, start with deg=2, out_ready=1, err_in nonzero at pos 200 and 10:
  - load high cycles 1-4, coef_idx 3,2,1,0.
  - 255 transfers.
  - done with fail=0, err_cnt=2.
- N=204, start:
  - shorten high exactly 51 cycles, then load 4 cycles.
  - first out_pos=203.
- Backpressure: out_ready toggled 1,0,0,1 in SEARCH:
  - search low while out_ready=0.
  - out_pos holds.
  - no position skipped or repeated.
- Mismatch: deg=3, only one nonzero err_in → done=1, fail=1, err_cnt=1.
- Ignored start: start pulsed during SEARCH → no restart; pos sequence unaffected.
- Abort: clrn asserted during LOAD → next cycle all outputs at reset values; a fresh start completes normally.
